// File: rtl/rs_seg_adder_pkg.sv
// -----------------------------------------------------------------------------
// rs_seg_adder_pkg
// Shared definitions for the segmented (multi-cycle) adder:
//   - state_e          : controller states IDLE / RUN / DONE
//   - nseg()           : number of SEG-bit segment cycles for a WIDTH-bit add
//   - MAX_CARRY_CHAIN  : longest slice we allow, so one slice maps onto a
//                        single dedicated carry chain
// -----------------------------------------------------------------------------
package rs_seg_adder_pkg;

  localparam int MAX_CARRY_CHAIN = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(width / seg)
  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/rs_seg_adder_slice.sv
// -----------------------------------------------------------------------------
// rs_seg_adder_slice
// Purely combinational SEG-bit adder used once per cycle by rs_seg_adder.
// Written as a plain "+" so synthesis maps it onto the carry chain.
//
// Ports:
//   a_i, b_i  [SEG-1:0]  operand segments
//   ci_i                 carry into bit 0
//   s_o       [SEG-1:0]  sum bits
//   co_o                 carry out of bit SEG-1
//   c_msb_o              carry into bit SEG-1 (for signed overflow)
// -----------------------------------------------------------------------------
module rs_seg_adder_slice #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o,
  output logic           c_msb_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};

  // The sum bit is a ^ b ^ carry-in, so the carry into the top bit falls out
  // of the sum without a second adder.
  assign c_msb_o = s_o[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];

endmodule

// File: rtl/rs_seg_adder.sv
// -----------------------------------------------------------------------------
// rs_seg_adder
// Multi-cycle WIDTH-bit adder/subtractor: Y = A + (BI ? ~B : B) + CI, one
// SEG-bit segment per clock, with valid/ready handshakes on both sides.
// A result appears ceil(WIDTH/SEG) cycles after the accepting edge and is held
// until the consumer takes it; a new operand set may be taken on that same edge.
//
// Ports:
//   C                     clock, rising edge
//   R                     asynchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, CI, BI)
//   A, B      [WIDTH-1:0] operands
//   CI                    carry-in
//   BI                    invert B (subtract when CI=1)
//   out_valid / out_ready result handshake (Y, CO, OV)
//   Y         [WIDTH-1:0] sum modulo 2^WIDTH
//   CO                    carry out of bit WIDTH-1
//   OV                    two's-complement overflow
//
// Build option:
//   RS_SEG_ADDER_OVF_EN   defined  -> OV is computed and registered
//                         undefined-> OV is tied low, no overflow flop
//
// Operand layout: operands are held in NSEG*SEG-bit registers. When the last
// segment is narrower than SEG, its real bits sit at the TOP of that segment
// and the unused low bits are padded with a=1, b=0. Those padding bits pass
// the incoming carry straight through, so the slice's own co/c_msb are exactly
// the carry out of / into bit WIDTH-1 with no special-case tap.
// -----------------------------------------------------------------------------
module rs_seg_adder
  import rs_seg_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG  = nseg(WIDTH, SEG);
  localparam int PAD_W = NSEG * SEG;
  localparam int LOW_W = (NSEG - 1) * SEG;  // bits held in full-width segments
  localparam int PAD   = PAD_W - WIDTH;     // padding bits in the last segment
  localparam int KW    = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  if (WIDTH < 2 || WIDTH > 1024 || SEG < 2 || SEG > WIDTH || SEG > MAX_CARRY_CHAIN)
  begin : g_bad_cfg
    $error("rs_seg_adder: illegal WIDTH/SEG combination");
  end

  // Position of operand bit i inside the padded segment layout.
  function automatic int lay_pos(input int i);
    return (i < LOW_W) ? i : i + PAD;
  endfunction

  function automatic logic [PAD_W-1:0] lay(input logic [WIDTH-1:0] v,
                                           input logic             pad_bit);
    logic [PAD_W-1:0] r;
    r = {PAD_W{pad_bit}};
    for (int i = 0; i < WIDTH; i++) r[lay_pos(i)] = v[i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [PAD_W-1:0] a_lay_q, a_lay_d;
  logic [PAD_W-1:0] b_lay_q, b_lay_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             init_q;   // low until the first edge after reset release
`ifdef RS_SEG_ADDER_OVF_EN
  logic             ov_q, ov_d;
`endif

  logic             accept;

  // ---------------------------------------------------------------------------
  // Segment adder
  // ---------------------------------------------------------------------------
  logic [SEG-1:0] seg_a, seg_b, seg_s;
  logic           seg_co;
`ifdef RS_SEG_ADDER_OVF_EN
  logic           seg_c_msb;
`else
  logic           seg_c_msb_unused;  // carry into the top bit only feeds OV
`endif

  assign seg_a = a_lay_q[int'(k_q) * SEG +: SEG];
  assign seg_b = b_lay_q[int'(k_q) * SEG +: SEG];

  rs_seg_adder_slice #(
    .SEG (SEG)
  ) u_slice (
    .a_i     (seg_a),
    .b_i     (seg_b),
    .ci_i    (carry_q),
    .s_o     (seg_s),
    .co_o    (seg_co),
`ifdef RS_SEG_ADDER_OVF_EN
    .c_msb_o (seg_c_msb)
`else
    .c_msb_o (seg_c_msb_unused)
`endif
  );

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // In DONE the slot frees up on the same edge the consumer takes the result,
  // which is what allows back-to-back operation.
  assign in_ready  = ((state_q == IDLE) && init_q) ||
                     ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_lay_d = a_lay_q;
    b_lay_d = b_lay_q;
    y_d     = y_q;
    co_d    = co_q;
`ifdef RS_SEG_ADDER_OVF_EN
    ov_d    = ov_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end

      RUN: begin
        // Only the bits of the current segment change; the rest of Y keeps
        // whatever it held before.
        for (int i = 0; i < WIDTH; i++) begin
          if (lay_pos(i) / SEG == int'(k_q)) y_d[i] = seg_s[lay_pos(i) % SEG];
        end
        carry_d = seg_co;
        if (k_q == K_LAST) begin
          k_d     = '0;
          co_d    = seg_co;
`ifdef RS_SEG_ADDER_OVF_EN
          ov_d    = seg_co ^ seg_c_msb;
`endif
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      DONE: begin
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Operand capture is shared by IDLE and the back-to-back path out of DONE.
    if (accept) begin
      a_lay_d = lay(A, 1'b1);
      b_lay_d = lay(B ^ {WIDTH{BI}}, 1'b0);
      carry_d = CI;
      k_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      co_q    <= 1'b0;
      init_q  <= 1'b0;
      // NOTE: the operand registers are reset as well; they carry no
      // architectural meaning outside RUN, but keeping them known avoids
      // X-propagation surprises in simulation.
      a_lay_q <= '0;
      b_lay_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      co_q    <= co_d;
      init_q  <= 1'b1;
      a_lay_q <= a_lay_d;
      b_lay_q <= b_lay_d;
    end
  end

`ifdef RS_SEG_ADDER_OVF_EN
  always_ff @(posedge C or negedge R) begin
    if (!R) ov_q <= 1'b0;
    else    ov_q <= ov_d;
  end
  assign OV = ov_q;
`else
  assign OV = 1'b0;
`endif

  assign Y  = y_q;
  assign CO = co_q;

endmodule

// File: tb/tb_rs_seg_adder.sv
// -----------------------------------------------------------------------------
// tb_rs_seg_adder
// Self-checking bench for rs_seg_adder. Two instances share clock, reset and
// operand buses: WIDTH=64/SEG=16 (four even segments) and WIDTH=40/SEG=16
// (three segments, last one 8 bits). Expected values come from a vector table
// and from a whole-word arithmetic model. Honours RS_SEG_ADDER_OVF_EN.
// -----------------------------------------------------------------------------
module tb_rs_seg_adder;

`ifdef RS_SEG_ADDER_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        C, R;
  logic [63:0] a_in, b_in;
  logic        ci_in, bi_in;

  logic        iv64, ir64, vld64, or64, co64, ovf64;
  logic [63:0] y64;
  logic        iv40, ir40, vld40, or40, co40, ovf40;
  logic [39:0] y40;

  int n_checks = 0;
  int n_errors = 0;

  rs_seg_adder #(.WIDTH(64), .SEG(16)) u_dut64 (
    .C(C), .R(R), .in_valid(iv64), .in_ready(ir64),
    .A(a_in), .B(b_in), .CI(ci_in), .BI(bi_in),
    .out_valid(vld64), .out_ready(or64), .Y(y64), .CO(co64), .OV(ovf64)
  );

  rs_seg_adder #(.WIDTH(40), .SEG(16)) u_dut40 (
    .C(C), .R(R), .in_valid(iv40), .in_ready(ir40),
    .A(a_in[39:0]), .B(b_in[39:0]), .CI(ci_in), .BI(bi_in),
    .out_valid(vld40), .out_ready(or40), .Y(y40), .CO(co40), .OV(ovf40)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    string       name;
    bit          w40;
    logic [63:0] a, b;
    logic        ci, bi;
    logic [63:0] y;
    logic        co, ov;
    int          lat;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_ready(input bit w40);
    return w40 ? ir40 : ir64;
  endfunction
  function automatic logic cur_valid(input bit w40);
    return w40 ? vld40 : vld64;
  endfunction
  function automatic logic [63:0] cur_y(input bit w40);
    return w40 ? {24'b0, y40} : y64;
  endfunction
  function automatic logic cur_co(input bit w40);
    return w40 ? co40 : co64;
  endfunction
  function automatic logic cur_ov(input bit w40);
    return w40 ? ovf40 : ovf64;
  endfunction

  // Whole-word reference: add the masked operands as plain integers and read
  // carry and signed overflow off the wide sum.
  function automatic void model(input bit w40, input logic [63:0] a_v, b_v,
                                input logic ci_v, bi_v,
                                output logic [63:0] y_e, output logic co_e, ov_e);
    int          w;
    logic [63:0] mask, am, bm;
    logic [64:0] full;
    w    = w40 ? 40 : 64;
    mask = w40 ? 64'h0000_00FF_FFFF_FFFF : '1;
    am   = a_v & mask;
    bm   = (bi_v ? ~b_v : b_v) & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'b0, ci_v};
    y_e  = full[63:0] & mask;
    co_e = full[w];
    ov_e = OVF & (am[w-1] == bm[w-1]) & (y_e[w-1] != am[w-1]);
  endfunction

  task automatic check_model(input string name, input bit w40, input logic [63:0] a_v, b_v,
                             input logic ci_v, bi_v);
    logic [63:0] ey;
    logic        eco, eov;
    model(w40, a_v, b_v, ci_v, bi_v, ey, eco, eov);
    check({name, "_y"},  cur_y(w40),        ey);
    check({name, "_co"}, 64'(cur_co(w40)),  64'(eco));
    check({name, "_ov"}, 64'(cur_ov(w40)),  64'(eov));
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic start_op(input bit w40, input logic [63:0] a_v, b_v, input logic ci_v, bi_v);
    int n = 0;
    while (!cur_ready(w40) && n < 50) begin
      @(posedge C); #1; n++;
    end
    if (!cur_ready(w40)) check("in_ready_timeout", 64'(cur_ready(w40)), 64'd1);
    a_in = a_v; b_in = b_v; ci_in = ci_v; bi_in = bi_v;
    if (w40) iv40 = 1'b1; else iv64 = 1'b1;
    @(posedge C); #1;
    iv40 = 1'b0; iv64 = 1'b0;
  endtask

  task automatic wait_done(input bit w40, output int lat);
    lat = 0;
    while (!cur_valid(w40) && lat < 50) begin
      @(posedge C); #1; lat++;
    end
  endtask

  task automatic consume(input bit w40);
    if (w40) or40 = 1'b1; else or64 = 1'b1;
    @(posedge C); #1;
    or40 = 1'b0; or64 = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    vec_t        vecs [10];
    int          lat;
    logic [63:0] a1, b1, a2, b2, y3, y4;
    logic        ci2, bi2, eco, eov;

    vecs[0] = '{"carry_all",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                64'h0, 1'b1, 1'b0, 4};
    vecs[1] = '{"sub_0m1",    1'b0, 64'h0, 64'h1, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4};
    vecs[2] = '{"sub_ovf",    1'b0, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, OVF, 4};
    vecs[3] = '{"add_ovf",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, OVF, 4};
    vecs[4] = '{"seg_ripple", 1'b0, 64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 4};
    vecs[5] = '{"no_carry",   1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 4};
    vecs[6] = '{"ci_only",    1'b0, 64'h0, 64'h0, 1'b1, 1'b0,
                64'h1, 1'b0, 1'b0, 4};
    vecs[7] = '{"w40_wrap",   1'b1, 64'h00FF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0, 1'b1, 1'b0, 3};
    vecs[8] = '{"w40_ovf",    1'b1, 64'h007F_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0080_0000_0000, 1'b0, OVF, 3};
    vecs[9] = '{"w40_sub",    1'b1, 64'h0, 64'h1, 1'b1, 1'b1,
                64'h00FF_FFFF_FFFF, 1'b0, 1'b0, 3};

    iv64 = 1'b0; or64 = 1'b0; iv40 = 1'b0; or40 = 1'b0;
    a_in = '0; b_in = '0; ci_in = 1'b0; bi_in = 1'b0;
    R = 1'b1;
    #2 R = 1'b0;

    // Reset state
    repeat (2) @(posedge C);
    #1;
    check("rst_in_ready",   64'(ir64),  64'd0);
    check("rst_out_valid",  64'(vld64), 64'd0);
    check("rst_y",          y64,        64'd0);
    check("rst_co",         64'(co64),  64'd0);
    check("rst_ov",         64'(ovf64), 64'd0);
    check("rst_in_ready40", 64'(ir40),  64'd0);

    @(negedge C);
    R = 1'b1;
    #1;
    check("rel_pre_edge_in_ready", 64'(ir64), 64'd0);
    @(posedge C); #1;
    check("rel_in_ready",   64'(ir64), 64'd1);
    check("rel_in_ready40", 64'(ir40), 64'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].w40, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].bi);
      wait_done(vecs[i].w40, lat);
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_y"},   cur_y(vecs[i].w40), vecs[i].y);
      check({vecs[i].name, "_co"},  64'(cur_co(vecs[i].w40)), 64'(vecs[i].co));
      check({vecs[i].name, "_ov"},  64'(cur_ov(vecs[i].w40)), 64'(vecs[i].ov));
      consume(vecs[i].w40);
    end

    // Backpressure: result held for 5 cycles while garbage operands are
    // offered, then released together with a new operand set.
    a1 = {$urandom(), $urandom()};
    b1 = {$urandom(), $urandom()};
    start_op(1'b0, a1, b1, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      a_in = {$urandom(), $urandom()};
      b_in = {$urandom(), $urandom()};
      iv64 = 1'b1;
      @(posedge C); #1;
      check_model("bp_hold", 1'b0, a1, b1, 1'b0, 1'b0);
      check("bp_out_valid", 64'(vld64), 64'd1);
      check("bp_in_ready",  64'(ir64),  64'd0);
    end
    a2 = {$urandom(), $urandom()};
    b2 = {$urandom(), $urandom()};
    ci2 = 1'($urandom_range(0, 1));
    bi2 = 1'($urandom_range(0, 1));
    a_in = a2; b_in = b2; ci_in = ci2; bi_in = bi2;
    iv64 = 1'b1; or64 = 1'b1;
    #1;
    check("b2b_in_ready", 64'(ir64), 64'd1);
    @(posedge C); #1;
    iv64 = 1'b0; or64 = 1'b0;
    check("b2b_out_valid", 64'(vld64), 64'd0);
    check("b2b_in_ready_run", 64'(ir64), 64'd0);
    wait_done(1'b0, lat);
    check("b2b_lat", 64'(lat), 64'd3 + 64'd1);
    check_model("b2b", 1'b0, a2, b2, ci2, bi2);
    consume(1'b0);

    // Partial update: after one segment cycle only bits [15:0] are new.
    a1 = {$urandom(), $urandom()};
    b1 = {$urandom(), $urandom()};
    model(1'b0, a1, b1, 1'b0, 1'b0, y3, eco, eov);
    start_op(1'b0, a1, b1, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    consume(1'b0);
    a2 = ~a1;
    b2 = {$urandom(), $urandom()};
    model(1'b0, a2, b2, 1'b1, 1'b0, y4, eco, eov);
    start_op(1'b0, a2, b2, 1'b1, 1'b0);
    @(posedge C); #1;
    check("partial_y", y64, {y3[63:16], y4[15:0]});
    wait_done(1'b0, lat);
    check_model("partial_done", 1'b0, a2, b2, 1'b1, 1'b0);
    consume(1'b0);

    // Randomised operations on both widths; operands scrambled during RUN.
    for (int i = 0; i < 40; i++) begin
      bit w40;
      w40 = 1'($urandom_range(0, 1));
      a1  = {$urandom(), $urandom()};
      b1  = {$urandom(), $urandom()};
      ci2 = 1'($urandom_range(0, 1));
      bi2 = 1'($urandom_range(0, 1));
      start_op(w40, a1, b1, ci2, bi2);
      a_in = {$urandom(), $urandom()};
      b_in = {$urandom(), $urandom()};
      ci_in = ~ci2;
      wait_done(w40, lat);
      check("rnd_lat", 64'(lat), w40 ? 64'd3 : 64'd4);
      check_model("rnd", w40, a1, b1, ci2, bi2);
      repeat ($urandom_range(0, 2)) begin
        @(posedge C); #1;
      end
      consume(w40);
    end

    // Reset in the middle of RUN (segment index 2).
    start_op(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1, 1'b0, 1'b0);
    @(posedge C); #1;
    @(posedge C); #1;
    R = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(vld64), 64'd0);
    check("mid_rst_y",         y64,        64'd0);
    check("mid_rst_co",        64'(co64),  64'd0);
    check("mid_rst_ov",        64'(ovf64), 64'd0);
    check("mid_rst_in_ready",  64'(ir64),  64'd0);
    @(negedge C);
    R = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge C); #1;
      check("mid_rst_no_stale", 64'(vld64), 64'd0);
    end
    a1 = {$urandom(), $urandom()};
    b1 = {$urandom(), $urandom()};
    start_op(1'b0, a1, b1, 1'b1, 1'b1);
    wait_done(1'b0, lat);
    check("post_rst_lat", 64'(lat), 64'd4);
    check_model("post_rst", 1'b0, a1, b1, 1'b1, 1'b1);
    consume(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_seg_adder.md
RS_SEG_ADDER -- requirements
Module: rs_seg_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: total operand/result width in bits, legal 2..1024.
REQ-002 SHALL have parameter SEG, default 16: bits added per cycle, legal 2..WIDTH.
REQ-003 SHALL have port C, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port R, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operands A/B/CI/BI valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands.
REQ-007 SHALL have ports A and B, input, WIDTH each: operands.
REQ-008 SHALL have port CI, input, 1: carry-in.
REQ-009 SHALL have port BI, input, 1: invert B (subtract when CI=1).
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port Y, output, WIDTH: sum A + (BI ? ~B : B) + CI, modulo 2^WIDTH.
REQ-013 SHALL have port CO, output, 1: carry out of bit WIDTH-1.
REQ-014 SHALL have port OV, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL have FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1; in_valid -> latch A, B^{WIDTH{BI}}, CI; seg index k=0; go RUN.
REQ-016 SHALL, in RUN, add one segment per cycle: bits [k*SEG +: SEG] plus registered carry; write sum bits into Y; register segment carry-out as next carry-in; k++.
REQ-017 SHALL handle a final segment narrower than SEG when WIDTH%SEG!=0; CO = carry out of bit WIDTH-1, not of the padded segment.
REQ-018 SHALL move RUN->DONE after NSEG=ceil(WIDTH/SEG) segment cycles; out_valid rises exactly NSEG cycles after the accepting edge.
REQ-019 SHALL, in DONE, hold out_valid, Y, CO and OV stable until out_ready=1; on out_valid&&out_ready, leave DONE.
REQ-020 SHALL, in DONE with out_ready=1, assert in_ready; simultaneous in_valid SHALL go straight to RUN (back-to-back, no bubble); otherwise go IDLE.
REQ-021 SHALL keep in_ready=0 throughout RUN, and in DONE while out_ready=0; operand changes there are ignored.
REQ-022 SHALL compute OV = carry into bit WIDTH-1 XOR CO, captured during the final segment.
REQ-023 SHALL keep Y bits of segments not yet computed at their previous value; only out_valid qualifies Y.

Reset
REQ-024 SHALL, on R=0 (any state, including mid-RUN), asynchronously force IDLE, k=0, carry=0, Y=0, CO=0, OV=0, out_valid=0, in_ready=0.
REQ-025 SHALL assert in_ready from the first rising edge after R deasserts; any partial result SHALL be discarded and never presented.

Configuration
REQ-026 SHALL use macro RS_SEG_ADDER_OVF_EN: defined -> OV computed per REQ-022; undefined -> OV tied 0 and the overflow register is not built.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and a constant function nseg(WIDTH,SEG) in package rs_seg_adder_pkg.
REQ-028 SHALL instantiate one sub-module rs_seg_adder_slice: combinational SEG-bit adder (a, b, ci -> s, co, c_msb), written as a plain "+" so synthesis maps it to an $alu on the carry chain.
REQ-029 SHALL keep SEG <= MAX_CARRY_CHAIN so each slice fits one hardware carry chain.

Verification
REQ-030 SHALL cover WIDTH=64 SEG=16: A=all ones, B=0, CI=1, BI=0 -> out_valid 4 cycles after accept, Y=0, CO=1, OV=0.
REQ-031 SHALL cover subtract: A=0, B=1, BI=1, CI=1 -> Y=all ones, CO=0; with macro, A=0x8000..0, B=1 -> OV=1.
REQ-032 SHALL cover WIDTH=40 SEG=16 (3 segments, last 8 bits): A=0xFF_FFFF_FFFF, B=1 -> Y=0, CO=1, latency 3.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles -> Y/CO/OV stable, in_ready=0; out_ready=1 with in_valid=1 -> next op accepted same edge.
REQ-034 SHALL cover reset mid-RUN: R low at segment 2 -> out_valid=0, Y=0 immediately; next op after release gives a correct result.
REQ-035 SHALL cover signed overflow: A=0x7FFF..F, B=1, macro defined -> OV=1; macro undefined -> OV=0.
